// File: rtl/aes_key_expander.sv
// Word-serial AES-128/192/256 key schedule: one 32-bit word per cycle, 128-bit round keys over valid/ready.
// Optional KEY_STORE_EN keeps every released round key for random read-back via rd_rndNo/rd_key.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  // Forward AES S-box; byte 8'h00 sits in the most significant byte.
  localparam logic [2047:0] TABLE = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_key_expander #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] ip_key,
  output logic [127:0]        op_key,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [3:0]          op_rndNo,
  output logic                busy,
  output logic                done
`ifdef KEY_STORE_EN
  ,
  input  logic [3:0]          rd_rndNo,
  output logic [127:0]        rd_key
`endif
);
  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);

  generate
    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
      $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t      state;
  logic [31:0] win [NK];   // win[0] = w[i-Nk], win[NK-1] = w[i-1]
  logic [31:0] acc [3];
  logic [5:0]  idx;
  logic [2:0]  phase;      // idx mod Nk
  logic [7:0]  rcon;

  logic [31:0]  last;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  word;
  logic [127:0] key_next;
  logic         accept;
  logic         adv;
  logic         rel;

  assign last   = win[NK-1];
  assign sub_in = (phase == 3'd0) ? {last[23:0], last[31:24]} : last;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .s (sub_out[8*b +: 8])
    );
  end

  // Next schedule word; the first Nk words simply recirculate the key through the window.
  always_comb begin
    word = win[0];
    if (idx >= 6'(NK)) begin
      if (phase == 3'd0) begin
        word = win[0] ^ sub_out ^ {rcon, 24'h0};
      end else if (NK == 8 && phase == 3'd4) begin
        word = win[0] ^ sub_out;
      end else begin
        word = win[0] ^ last;
      end
    end
  end

  assign key_next = {acc[0], acc[1], acc[2], word};
  assign accept   = op_valid & op_ready;
  // Only the word that completes a round key can be blocked by an unconsumed key.
  assign adv      = (state == GEN) && !(idx[1:0] == 2'd3 && op_valid && !op_ready);
  assign rel      = adv && (idx[1:0] == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      for (int unsigned j = 0; j < NK; j++) win[j] <= '0;
      for (int unsigned j = 0; j < 3; j++) acc[j] <= '0;
      idx      <= '0;
      phase    <= '0;
      rcon     <= 8'h01;
      op_key   <= '0;
      op_valid <= 1'b0;
      op_rndNo <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) op_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned j = 0; j < NK; j++) win[j] <= ip_key[KEY_BITS-1-32*j -: 32];
            idx   <= '0;
            phase <= '0;
            rcon  <= 8'h01;
            busy  <= 1'b1;
            state <= GEN;
          end
        end
        GEN: begin
          if (adv) begin
            for (int unsigned j = 0; j + 1 < NK; j++) win[j] <= win[j+1];
            win[NK-1] <= word;
            case (idx[1:0])
              2'd0:    acc[0] <= word;
              2'd1:    acc[1] <= word;
              2'd2:    acc[2] <= word;
              default: ;
            endcase
            if (rel) begin
              op_key   <= key_next;
              op_rndNo <= idx[5:2];
              op_valid <= 1'b1;
            end
            phase <= (phase == 3'(NK-1)) ? 3'd0 : phase + 3'd1;
            if (idx >= 6'(NK) && phase == 3'd0) begin
              rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            if (idx == 6'(NW-1)) begin
              state <= DRAIN;
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_STORE_EN
  logic [127:0] store [NR+1];

  // Round-key archive for decryption; wiped on reset and on each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= NR; k++) store[k] <= '0;
    end else if (state == IDLE && start) begin
      for (int unsigned k = 0; k <= NR; k++) store[k] <= '0;
    end else if (rel) begin
      for (int unsigned k = 0; k <= NR; k++) begin
        if (idx[5:2] == 4'(k)) store[k] <= key_next;
      end
    end
  end

  always_comb begin
    rd_key = '0;
    for (int unsigned k = 0; k <= NR; k++) begin
      if (rd_rndNo == 4'(k)) rd_key = store[k];
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: AES-128/192/256 instances against a FIPS-197 style reference
// schedule built from an arithmetically derived S-box; covers known vectors, backpressure, start-while-busy, reset.

module tb_aes_key_expander;
  logic         clk;
  logic         rst_n;
  logic [2:0]   start;
  logic [2:0]   ready;
  logic [2:0]   valid;
  logic [2:0]   busy;
  logic [2:0]   done;
  logic [255:0] kin  [3];
  logic [127:0] okey [3];
  logic [3:0]   ornd [3];
`ifdef KEY_STORE_EN
  logic [3:0]   rdn  [3];
  logic [127:0] rdk  [3];
`endif

  int checks;
  int errors;

  logic [7:0]   sb  [256];
  logic [31:0]  mw  [60];
  logic [127:0] got [3][15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_key_expander #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .ip_key(kin[0][255:128]),
    .op_key(okey[0]), .op_valid(valid[0]), .op_ready(ready[0]), .op_rndNo(ornd[0]),
    .busy(busy[0]), .done(done[0])
`ifdef KEY_STORE_EN
    , .rd_rndNo(rdn[0]), .rd_key(rdk[0])
`endif
  );

  aes_key_expander #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .ip_key(kin[1][255:64]),
    .op_key(okey[1]), .op_valid(valid[1]), .op_ready(ready[1]), .op_rndNo(ornd[1]),
    .busy(busy[1]), .done(done[1])
`ifdef KEY_STORE_EN
    , .rd_rndNo(rdn[1]), .rd_key(rdk[1])
`endif
  );

  aes_key_expander #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .ip_key(kin[2]),
    .op_key(okey[2]), .op_valid(valid[2]), .op_ready(ready[2]), .op_rndNo(ornd[2]),
    .busy(busy[2]), .done(done[2])
`ifdef KEY_STORE_EN
    , .rd_rndNo(rdn[2]), .rd_key(rdk[2])
`endif
  );

  task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box = affine map of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, "_key"},   okey[d], 128'h0);
    check({tag, "_valid"}, 128'(valid[d]), 128'h0);
    check({tag, "_rnd"},   128'(ornd[d]), 128'h0);
    check({tag, "_busy"},  128'(busy[d]), 128'h0);
    check({tag, "_done"},  128'(done[d]), 128'h0);
  endtask

  // One expansion on instance d; duty = percent of cycles op_ready is high; abort_at = cycle to pulse reset (-1: none).
  task automatic run(input int d, input logic [255:0] key, input int duty, input int abort_at);
    int          nk;
    int          nr;
    int          cyc;
    int          rnd;
    bit          fin;
    bit          last_acc;
    bit          prev_stall;
    logic [127:0] prev_key;
    nk = 4 + 2 * d;
    nr = nk + 6;
    model(nk, key);
    @(negedge clk);
    kin[d]   = key;
    start[d] = 1'b1;
    ready[d] = 1'b1;
    @(negedge clk);
    cyc = 0; rnd = 0; fin = 0; last_acc = 0; prev_stall = 0; prev_key = '0;
    while (!fin && cyc < 1000) begin
      if (cyc == abort_at) begin
        rst_n    = 1'b0;
        start[d] = 1'b0;
        #1;
        check_idle_outputs(d, "abort");
`ifdef KEY_STORE_EN
        rdn[d] = 4'd0;
        #1;
        check("abort_store", rdk[d], 128'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_novalid", 128'(valid[d]), 128'h0);
        return;
      end
      // A second start mid-run carries a different key and must be ignored.
      if (cyc == 8) begin
        start[d] = 1'b1;
        kin[d]   = ~key;
      end else begin
        start[d] = 1'b0;
      end
      ready[d] = (duty >= 100) ? 1'b1 : 1'(($urandom_range(99) < 32'(duty)) ? 1 : 0);
      if (cyc == 0) check("busy_start", 128'(busy[d]), 128'h1);
      check("done", 128'(done[d]), 128'(last_acc));
      if (last_acc) begin
        check("busy_end",  128'(busy[d]), 128'h0);
        check("valid_end", 128'(valid[d]), 128'h0);
        fin = 1;
      end
      if (prev_stall) begin
        check("hold_valid", 128'(valid[d]), 128'h1);
        check("hold_key", okey[d], prev_key);
      end
      prev_stall = valid[d] && !ready[d];
      prev_key   = okey[d];
      last_acc   = 0;
      if (!fin && valid[d] && ready[d]) begin
        check("rnd", 128'(ornd[d]), 128'(rnd));
        check("key", okey[d], rk(rnd));
        if (duty >= 100) check("latency", 128'(cyc), 128'(4 * (rnd + 1)));
        if (rnd < 15) got[d][rnd] = okey[d];
        if (rnd == nr) last_acc = 1;
        rnd++;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check("timeout", 128'h0, 128'h1);
    check("rounds", 128'(rnd), 128'(nr + 1));
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = '0;
    ready  = '0;
    for (int d = 0; d < 3; d++) begin
      kin[d] = '0;
`ifdef KEY_STORE_EN
      rdn[d] = '0;
`endif
    end
    build_sbox();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle_outputs(d, "reset");
    rst_n = 1'b1;

    run(0, K128, 100, -1);
    check("aes128_r1",  got[0][1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_r10", got[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef KEY_STORE_EN
    for (int r = 0; r < 12; r++) begin
      rdn[0] = 4'(r);
      #1;
      check("store_rd", rdk[0], (r <= 10) ? rk(r) : 128'h0);
    end
`endif

    run(1, K192, 100, -1);
    check("aes192_r12", got[1][12], 128'ha4970a331a78dc09c418c271e3a41d5d);
    run(2, K256, 100, -1);
    check("aes256_r14", got[2][14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    run(0, K128, 30, -1);
    run(1, rand_key(), 30, -1);
    run(2, rand_key(), 30, -1);
    run(1, rand_key(), 100, -1);
    run(2, rand_key(), 100, -1);

    run(0, rand_key(), 100, 21);
    run(0, K128, 100, -1);
    check("fresh_r10", got[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(0, rand_key(), 30, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Sequential, word-serial AES key expansion engine supporting AES-128/192/256, selected by parameter.
- Takes one cipher key per start pulse and produces one 32-bit schedule word per cycle using a single 4-byte aes_sbox bank.
- Emits 128-bit round keys 0..Nr in order over a valid/ready handshake.
- Feeds the iterative round datapath, replacing per-round combinational key derivation.

Parameters:
KEY_BITS, 128, cipher key width. Legal values are 128, 192, 256; any other value is an elaboration error. Derived: Nk = KEY_BITS/32, Nr = Nk+6, NW = 4*(Nr+1) = 44/52/60 words.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin expansion of ip_key; honoured only when busy=0
ip_key  input  KEY_BITS  cipher key; word 0 in MSBs
op_key  output  128  current round key; word 4r in [127:96]
op_valid  output  1  op_key holds an unconsumed round key
op_ready  input  1  consumer accepts op_key when op_valid & op_ready
op_rndNo  output  4  round index of op_key, 0..Nr
busy  output  1  expansion in progress
done  output  1  one-cycle pulse when round Nr key is accepted

Behaviour:
- Reset (async, rst_n=0): op_key=0, op_valid=0, op_rndNo=0, busy=0, done=0. Window, accumulator, word counter and rcon are cleared (rcon is set to 8'h01). Reset mid-expansion aborts silently; no partial keys are presented afterwards.
- States: IDLE, GEN, DRAIN.
- IDLE: on start=1 at edge E0, latch ip_key into an Nk-word window, set word index i=0, rcon=8'h01, busy=1, go to GEN. start while busy=1 is ignored.
- GEN: produce word i each unblocked cycle:
  - i<Nk: w[i] = key word i.
  - i>=Nk: w[i] = w[i-Nk] ^ t, with t depending on i mod Nk:
    - i mod Nk==0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon advances by xtime (01,02,04,...,80,1b,36).
    - Nk==8 and i mod Nk==4: t = SubWord(w[i-1]).
    - otherwise: t = w[i-1].
  - The window shifts by one word per produced word. Word i goes to accumulator slot i mod 4.
- Round key release: when slot 3 fills, load op_key, set op_rndNo=i/4 and op_valid=1 on that edge.
- Stall rule: a 4th-slot word is not produced while op_valid=1 and op_ready=0 in that cycle. The accumulator and window then hold, and i does not advance. Simultaneous accept and reload in one cycle is allowed (zero-bubble).
- After word NW-1 is produced, go to DRAIN. DRAIN: when the final key (op_rndNo=Nr) is accepted, pulse done=1, clear op_valid and busy, go to IDLE.
- op_valid falls on accept unless reloaded on the same edge. op_key/op_rndNo stay stable while op_valid=1 and op_ready=0.
- Latency with op_ready tied high: round 0 key valid after edge E4, round r after edge E4(r+1). AES-128 completes at E44, AES-192 at E52, AES-256 at E60; done pulses on the following cycle.
- SubWord uses 4 aes_sbox instances on the selected 32-bit operand. No other sbox instances are used.

Optional Feature:
KEY_STORE_EN
- Defined: adds ports rd_rndNo (input, 4) and rd_key (output, 128), plus an internal (Nr+1)x128 register array.
  - Each round key is written to the array as it is released.
  - rd_key = array[rd_rndNo] combinationally; 0 for rd_rndNo>Nr.
  - Contents persist until the next start or reset; reset clears the array.
  - Provides reverse-order key supply for decryption without re-expansion.
- Undefined: no array and no rd_* ports; behaviour otherwise identical.

Test Plan:
- KEY_BITS=128, ip_key=2b7e151628aed2a6abf7158809cf4f3c, op_ready=1 -> round1 a0fafe1788542cb123a339392a6c7605; round10 d014f9a8c9ee2589e13f0cc8b6630ca6 after E44; done the next cycle.
- KEY_BITS=192, ip_key=000102...1617 -> round12 key a4970a331a78dc09c418c271e3a41d5d; 13 keys total, op_rndNo 0..12.
- KEY_BITS=256, ip_key=000102...1e1f -> round14 key 24fc79ccbf0979e9371ac23c6d68de36; exercises the i mod 8==4 SubWord path.
- Backpressure: op_ready random 30% duty -> identical key sequence, op_key stable while stalled, no dropped or duplicated rounds.
- start pulsed while busy; rst_n pulsed low at word 20 -> second start ignored; after reset all outputs 0; a fresh start gives correct round 0..10 keys.
- KEY_STORE_EN defined, AES-128 run, then rd_rndNo=10 -> rd_key=d014f9a8c9ee2589e13f0cc8b6630ca6; rd_rndNo=11 -> 0.
